// File: rtl/fetch_ref_chroma_load_pkg.sv
// Shared definitions for the chroma reference-window loader: widths, row counts, FSM encodings.
package fetch_ref_chroma_load_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int PIC_Y_WIDTH = 8;
    localparam int ROW_PIX     = 96;
    localparam int ROW_W       = ROW_PIX * PIXEL_WIDTH;

    localparam logic [5:0] ROWS_FULL   = 6'd48;
    localparam logic [5:0] ROWS_EDGE   = 6'd40;
    localparam logic [5:0] ROWS_SINGLE = 6'd32;
    localparam logic [2:0] BEAT_LAST   = 3'd5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Top and bottom LCU rows lose their out-of-picture padding rows.
    function automatic logic [5:0] row_count(input logic [PIC_Y_WIDTH-1:0] cur_y,
                                             input logic [PIC_Y_WIDTH-1:0] total_y);
        logic top, bot;
        top = (cur_y == '0);
        bot = (cur_y == total_y);
        if (top && bot)      return ROWS_SINGLE;
        else if (top || bot) return ROWS_EDGE;
        else                 return ROWS_FULL;
    endfunction

endpackage

// File: rtl/fetch_ref_chroma_load_deinterleave.sv
// chroma_deinterleave: merges one interleaved u,v read beat into the assembled row (u upper, v lower).
module chroma_deinterleave
    import fetch_ref_chroma_load_pkg::*;
#(
    parameter int BEAT_PIX = 16
) (
    input  logic [2:0]                      beat_i,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0] data_i,
    input  logic [ROW_W-1:0]                row_i,
    output logic [ROW_W-1:0]                row_o
);

    localparam int P      = PIXEL_WIDTH;
    localparam int PAIRS  = BEAT_PIX / 2;
    localparam int BEAT_W = BEAT_PIX * P;

    always_comb begin
        row_o = row_i;
        for (int j = 0; j < PAIRS; j++) begin
            row_o[ROW_W-1   - (int'(beat_i)*PAIRS + j)*P -: P] = data_i[BEAT_W-1 - 2*j*P -: P];
            row_o[ROW_W/2-1 - (int'(beat_i)*PAIRS + j)*P -: P] = data_i[BEAT_W-1 - (2*j+1)*P -: P];
        end
    end

endmodule

// File: rtl/fetch_ref_chroma_load.sv
// Loads one LCU chroma reference window row by row into the external buffer.
// Optional FETCH_CHROMA_OVERLAP_EN: request row r+1 while row r beats are still arriving.
module fetch_ref_chroma_load
    import fetch_ref_chroma_load_pkg::*;
#(
    parameter int BEAT_PIX = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sysif_start_i,
    input  logic [PIC_Y_WIDTH-1:0]          sysif_total_y_i,
    input  logic [PIC_Y_WIDTH-1:0]          cur_y_i,
    output logic                            rd_req_o,
    output logic [5:0]                      rd_row_o,
    input  logic                            rd_ack_i,
    input  logic                            rd_valid_i,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0] rd_data_i,
    output logic                            ext_load_valid_o,
    output logic [5:0]                      ext_load_addr_o,
    output logic [ROW_W-1:0]                ext_load_data_o,
    output logic                            ext_load_done_o,
    output logic                            busy_o
);

    logic [2:0]       state_q, state_d;
    logic [5:0]       row_q, row_d;
    logic [5:0]       n_q, n_d;
    logic [2:0]       beat_q, beat_d;
    logic [ROW_W-1:0] line_q, line_d, line_merged;
    logic             pend_q, pend_d;
    logic             seen_q, seen_d;
    logic             last_row;

    chroma_deinterleave #(.BEAT_PIX(BEAT_PIX)) u_deint (
        .beat_i (beat_q),
        .data_i (rd_data_i),
        .row_i  (line_q),
        .row_o  (line_merged)
    );

    assign last_row = (row_q == n_q - 6'd1);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        n_d     = n_q;
        beat_d  = beat_q;
        line_d  = line_q;
        pend_d  = pend_q;
        seen_d  = seen_q;
        case (state_q)
            S_IDLE: if (sysif_start_i) begin
                state_d = S_REQ;
                row_d   = '0;
                beat_d  = '0;
                n_d     = row_count(cur_y_i, sysif_total_y_i);
            end
            S_REQ: if (rd_ack_i) begin
                state_d = S_DATA;
                beat_d  = '0;
            end
            S_DATA: begin
                if (rd_valid_i) begin
                    line_d = line_merged;
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
`ifdef FETCH_CHROMA_OVERLAP_EN
                    if (beat_q == '0 && !last_row && !pend_q && !seen_q) pend_d = 1'b1;
`endif
                end
`ifdef FETCH_CHROMA_OVERLAP_EN
                if (pend_q && rd_ack_i) begin
                    pend_d = 1'b0;
                    seen_d = 1'b1;
                end
`endif
            end
            S_WRITE: begin
                if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q + 6'd1;
`ifdef FETCH_CHROMA_OVERLAP_EN
                    // An ack already taken for the next row skips the REQ cycle.
                    state_d = (seen_q || (pend_q && rd_ack_i)) ? S_DATA : S_REQ;
                    pend_d  = 1'b0;
                    seen_d  = 1'b0;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            n_q     <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            pend_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            pend_q  <= pend_d;
            seen_q  <= seen_d;
        end
    end

    assign rd_req_o         = (state_q == S_REQ) || pend_q;
    assign rd_row_o         = pend_q ? row_q + 6'd1 : row_q;
    assign ext_load_valid_o = (state_q == S_WRITE);
    assign ext_load_addr_o  = row_q;
    assign ext_load_data_o  = line_q;
    assign ext_load_done_o  = (state_q == S_DONE);
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_ref_chroma_load.sv
// Scoreboard bench for fetch_ref_chroma_load: expected rows queued as beats are driven, popped on writes.
module tb_fetch_ref_chroma_load;
    import fetch_ref_chroma_load_pkg::*;

    localparam int P  = PIXEL_WIDTH;
    localparam int BP = 16;
    localparam int BW = BP * P;
    localparam int LW = ROW_W;

    typedef struct {
        logic [5:0]    addr;
        logic [LW-1:0] data;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   sysif_start_i = 1'b0;
    logic [PIC_Y_WIDTH-1:0] sysif_total_y_i = '0;
    logic [PIC_Y_WIDTH-1:0] cur_y_i = '0;
    logic                   rd_req_o;
    logic [5:0]             rd_row_o;
    logic                   rd_ack_i = 1'b0;
    logic                   rd_valid_i = 1'b0;
    logic [BW-1:0]          rd_data_i = '0;
    logic                   ext_load_valid_o;
    logic [5:0]             ext_load_addr_o;
    logic [LW-1:0]          ext_load_data_o;
    logic                   ext_load_done_o;
    logic                   busy_o;

    fetch_ref_chroma_load #(.BEAT_PIX(BP)) dut (
        .clk              (clk),
        .rst              (rst),
        .sysif_start_i    (sysif_start_i),
        .sysif_total_y_i  (sysif_total_y_i),
        .cur_y_i          (cur_y_i),
        .rd_req_o         (rd_req_o),
        .rd_row_o         (rd_row_o),
        .rd_ack_i         (rd_ack_i),
        .rd_valid_i       (rd_valid_i),
        .rd_data_i        (rd_data_i),
        .ext_load_valid_o (ext_load_valid_o),
        .ext_load_addr_o  (ext_load_addr_o),
        .ext_load_data_o  (ext_load_data_o),
        .ext_load_done_o  (ext_load_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    wr_t sb[$];
    int  wr_cyc[$];
    int  checks = 0, errors = 0;
    int  cyc = 0, acks = 0, wr_cnt = 0, done_cnt = 0;
    int  last_wr_cyc = 0, last_addr = 0;
    int  ack_dly = 0, ack_wait = 0;
    bit  gaps = 1'b0;
    wr_t mon_e;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write/done monitor, sampled 1 unit after the active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (ext_load_valid_o) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", LW'(ext_load_addr_o), '1);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", LW'(ext_load_addr_o), LW'(mon_e.addr));
                chk("wr_data", ext_load_data_o, mon_e.data);
            end
            wr_cnt++;
            last_wr_cyc = cyc;
            last_addr   = int'(ext_load_addr_o);
            wr_cyc.push_back(cyc);
        end
        if (ext_load_done_o) begin
            done_cnt++;
            chk("done_latency", LW'(cyc - last_wr_cyc), LW'(1));
        end
    end

    // Read-port responder: acks a held request after ack_dly cycles.
    always begin
        @(negedge clk);
        rd_ack_i = 1'b0;
        if (!rd_req_o) begin
            ack_wait = 0;
        end else if (ack_wait >= ack_dly) begin
            rd_ack_i = 1'b1;
            ack_wait = 0;
            @(posedge clk);
            #1 acks++;
        end else begin
            ack_wait++;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req"},   LW'(rd_req_o),         '0);
        chk({tag, "_row"},   LW'(rd_row_o),         '0);
        chk({tag, "_valid"}, LW'(ext_load_valid_o), '0);
        chk({tag, "_addr"},  LW'(ext_load_addr_o),  '0);
        chk({tag, "_data"},  ext_load_data_o,       '0);
        chk({tag, "_done"},  LW'(ext_load_done_o),  '0);
        chk({tag, "_busy"},  LW'(busy_o),           '0);
    endtask

    task automatic drive_beats(input int r, input bit pat);
        logic [BW-1:0] bd;
        logic [LW-1:0] exp_row;
        logic [P-1:0]  u, v;
        int            c;
        exp_row = '0;
        for (int b = 0; b < 6; b++) begin
            bd = '0;
            for (int j = 0; j < BP/2; j++) begin
                c = 8*b + j;
                u = pat ? P'(c) : P'($urandom);
                v = pat ? P'(8'h80 + c) : P'($urandom);
                bd[BW-1 - 2*j*P -: P]     = u;
                bd[BW-1 - (2*j+1)*P -: P] = v;
                exp_row[LW-1 - c*P -: P]   = u;
                exp_row[LW/2-1 - c*P -: P] = v;
            end
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    rd_valid_i = 1'b0;
                    @(negedge clk);
                end
            end
            rd_valid_i = 1'b1;
            rd_data_i  = bd;
            if (b == 5) sb.push_back('{addr: 6'(r), data: exp_row});
            @(negedge clk);
        end
        rd_valid_i = 1'b0;
    endtask

    // Runs one window; start_at pulses a start while busy, abort_at resets before that row.
    task automatic run_window(input int cur, input int total, input int n_exp, input bit pat,
                              input int start_at, input int abort_at);
        int t;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        wr_cyc.delete();
        wr_cnt = 0; done_cnt = 0; acks = 0;
        cur_y_i = PIC_Y_WIDTH'(cur);
        sysif_total_y_i = PIC_Y_WIDTH'(total);
        sysif_start_i = 1'b1;
        @(negedge clk);
        sysif_start_i = 1'b0;
        for (int r = 0; r < n_exp; r++) begin
            if (r == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle_outputs("abort");
                drive_beats(r, pat);
                sb.delete();
                repeat (20) @(negedge clk);
                chk("abort_writes", LW'(wr_cnt), LW'(abort_at));
                chk("abort_no_done", LW'(done_cnt), '0);
                chk("abort_busy", LW'(busy_o), '0);
                return;
            end
            if (r == start_at) begin
                cur_y_i = '0;
                sysif_start_i = 1'b1;
                @(negedge clk);
                sysif_start_i = 1'b0;
                cur_y_i = PIC_Y_WIDTH'(cur);
            end
            t = 0;
            while (!(acks > r && !ext_load_valid_o) && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                chk("ack_timeout", LW'(r), '1);
                return;
            end
            drive_beats(r, pat);
        end
        t = 0;
        while (done_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("n_writes", LW'(wr_cnt), LW'(n_exp));
        chk("done_count", LW'(done_cnt), LW'(1));
        chk("last_addr", LW'(last_addr), LW'(n_exp - 1));
        chk("sb_empty", LW'(sb.size()), '0);
        chk("idle_busy", LW'(busy_o), '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Beats in IDLE must not disturb the next window.
        for (int i = 0; i < 4; i++) begin
            rd_valid_i = 1'b1;
            rd_data_i  = {BW/32{$urandom}};
            @(negedge clk);
        end
        rd_valid_i = 1'b0;

        run_window(3, 8, 48, 1'b0, -1, -1);
`ifdef FETCH_CHROMA_OVERLAP_EN
        chk("row_period", LW'(wr_cyc.size() >= 2 ? wr_cyc[1] - wr_cyc[0] : 0), LW'(7));
`else
        chk("row_period", LW'(wr_cyc.size() >= 2 ? wr_cyc[1] - wr_cyc[0] : 0), LW'(8));
`endif
        run_window(0, 8, 40, 1'b0, -1, -1);
        run_window(8, 8, 40, 1'b0, -1, -1);
        run_window(0, 0, 32, 1'b0, -1, -1);
        run_window(3, 8, 48, 1'b1, -1, -1);
        run_window(3, 8, 48, 1'b0, 10, -1);
        run_window(3, 8, 48, 1'b0, 10, 20);
        ack_dly = 5;
        gaps    = 1'b1;
        run_window(5, 8, 48, 1'b0, -1, -1);
        run_window(0, 8, 40, 1'b1, -1, -1);
        ack_dly = 0;
        gaps    = 1'b0;
        run_window(8, 8, 40, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ref_chroma_load.md
FETCH_REF_CHROMA_LOAD -- requirements
Module: fetch_ref_chroma_load

Interface
REQ-001 The block SHALL have parameter BEAT_PIX, default 16, meaning chroma samples per read beat (interleaved u,v); 96/BEAT_PIX beats per row, fixed at 6.
REQ-002 The block SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port sysif_start_i, input, 1, a one-cycle pulse that starts the load of one LCU chroma window.
REQ-005 The block SHALL have port sysif_total_y_i, input, `PIC_Y_WIDTH, the last LCU row index.
REQ-006 The block SHALL have port cur_y_i, input, `PIC_Y_WIDTH, the LCU row of the window, sampled on start.
REQ-007 The block SHALL have port rd_req_o, input-side request, output, 1, a row read request held until acknowledged.
REQ-008 The block SHALL have port rd_row_o, output, 6, the window row index being requested.
REQ-009 The block SHALL have port rd_ack_i, input, 1, request accepted.
REQ-010 The block SHALL have ports rd_valid_i (input, 1) and rd_data_i (input, BEAT_PIX*`PIXEL_WIDTH), carrying read beats of interleaved u,v samples.
REQ-011 The block SHALL have ports ext_load_valid_o (output, 1), ext_load_addr_o (output, 6) and ext_load_data_o (output, 96*`PIXEL_WIDTH), forming the buffer write port: u half upper, v half lower.
REQ-012 The block SHALL have port ext_load_done_o, output, 1, a one-cycle pulse after the last row is written.
REQ-013 The block SHALL have port busy_o, output, 1, high while not IDLE.

Function
REQ-014 The row count N SHALL be 48, except 40 when cur_y==0 or cur_y==total_y, and 32 when both hold.
REQ-015 The FSM SHALL have states IDLE, REQ, DATA, WRITE and DONE:
- IDLE->REQ on start.
- REQ->DATA on rd_ack_i.
- DATA->WRITE on the 6th rd_valid_i.
- WRITE->REQ, or ->DONE when the row equals N-1.
- DONE->IDLE after one cycle.
REQ-016 rd_req_o SHALL be high in REQ only, and rd_row_o SHALL equal the current row counter.
REQ-017 Beat b (0..5), pair j (0..7) SHALL map so that the u sample at bits [16P-1-2jP -: P] is written to u column c=8b+j at ext_load_data_o[96P-1-cP -: P], and the v sample at the next P bits is written to [48P-1-cP -: P], where P=`PIXEL_WIDTH.
REQ-018 ext_load_valid_o SHALL pulse for exactly one cycle in WRITE, with addr equal to the row and data holding the fully assembled row; the write SHALL occur 1 cycle after the 6th beat.
REQ-019 ext_load_done_o SHALL be asserted in DONE only, i.e. 1 cycle after the final write.
REQ-020 rd_valid_i outside DATA SHALL be ignored, and rd_ack_i outside REQ SHALL be ignored.
REQ-021 sysif_start_i while busy_o is high SHALL be ignored, with no restart and no state change.
REQ-022 The beat counter SHALL wrap 5->0, and the row counter SHALL reset to 0 on start.

Reset
REQ-023 When rst is high at a clk edge, the FSM SHALL go to IDLE, all counters SHALL go to 0, and all outputs SHALL be 0, including ext_load_data_o.
REQ-024 Reset mid-load SHALL abandon the window with no done pulse, and later beats SHALL be ignored until a new request.

Configuration
REQ-025 With FETCH_CHROMA_OVERLAP_EN defined, rd_req_o for row r+1 SHALL be raised in DATA once beat 0 of row r arrives; the ack is remembered, and WRITE then proceeds directly to DATA if the ack was already seen.
REQ-026 Without FETCH_CHROMA_OVERLAP_EN, requests SHALL be strictly serial per REQ-015.
REQ-027 With or without the macro, write order, data and done timing relative to the last write SHALL be identical.

Structure
REQ-028 The shared definitions package SHALL carry PIXEL_WIDTH, PIC_Y_WIDTH, the FSM state encodings, and the row constants 48/40/32.
REQ-029 One sub-module, chroma_deinterleave, SHALL be combinational: beat plus index to u/v column slices.

Verification
REQ-030 The bench SHALL cover each of the following scenarios:
- Middle row: cur_y=3, total_y=8 -> 48 writes, addr 0..47, done 1 cycle after addr 47.
- Top row: cur_y=0, total_y=8 -> exactly 40 writes; bottom row: cur_y=8 -> exactly 40.
- Single-row picture: cur_y=0, total_y=0 -> exactly 32 writes.
- Deinterleave: beat b pair j = {u=8b+j, v=0x80+8b+j} -> u column c=c, v column c=0x80+c for all 48.
- Start pulse at row 10 while busy -> ignored, row count unchanged; rst at row 20 -> outputs 0, no done.
- Ack delayed 5 cycles and rd_valid gaps -> data unchanged; with FETCH_CHROMA_OVERLAP_EN and zero-latency ack, row period = 7 cycles.
